johnson_seq_ctrl: RTL and testbench
===================================

Name: johnson_seq_ctrl

Overview:
Command-driven controller that owns and sequences a Johnson-counter phase register.
- Accepts commands over a valid/ready handshake: clear, load, run N steps, free-run, stop.
- Steps the register forward or reverse, counts steps, and flags and repairs illegal (non-Johnson) codes.
- Sits between the host/sequencer and any logic consuming Johnson phases.

Parameters:
WIDTH, 4, Johnson register width (>=2); 2*WIDTH legal states
CNT_W, 8, width of step count / run-length field (>=WIDTH)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_op  in  3  0 NOP, 1 CLEAR, 2 LOAD, 3 RUN_N, 4 RUN_FREE, 5 STOP, 6-7 treated as NOP
cmd_dir  in  1  1 forward, 0 reverse (sampled on RUN_N/RUN_FREE accept)
cmd_arg  in  CNT_W  step count for RUN_N; bits [WIDTH-1:0] are load value for LOAD
out  out  WIDTH  Johnson phase register
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at RUN_N completion
err_illegal  out  1  one-cycle pulse when illegal LOAD value was repaired
step_cnt  out  CNT_W  steps taken since last CLEAR/reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): out=0, state=IDLE, step_cnt=0, done=0, err_illegal=0, remaining=0, dir=1. cmd_ready=1 once released.
- Accept = cmd_valid & cmd_ready at a rising edge.
- cmd_ready is combinational from state only: 1 in IDLE and RUN_FREE, 0 in RUN_N and DONE.
- Forward step: out <= {out[W-2:0], ~out[W-1]}.
- Reverse step: out <= {~out[0], out[W-1:1]}.
- Every step increments step_cnt by 1 (wraps).
- Legal code: count of i in 0..W-2 with out[i]!=out[i+1] is <=1.
- States: IDLE, RUN_N, RUN_FREE, DONE.
- IDLE accepts:
  - NOP: no effect.
  - CLEAR: out=0, step_cnt=0 at the accept edge.
  - LOAD: legal value -> out=value. Illegal value -> out=0, and err_illegal=1 for the following cycle. step_cnt unchanged.
  - RUN_N, cmd_arg=N>0: latch dir, remaining=N, go RUN_N.
  - RUN_N, N=0: go DONE, no step.
  - RUN_FREE: latch dir, go RUN_FREE.
  - STOP: no effect.
- RUN_N:
  - One step per edge starting the edge after accept, so steps occur at edges T+1..T+N; remaining decrements each step.
  - On the step where remaining==1, go DONE.
  - No commands accepted.
- DONE: lasts exactly one cycle with done=1, then IDLE. done is 0 in all other states.
- RUN_FREE:
  - Steps on every edge except an accept edge.
  - STOP accept: no step, go IDLE.
  - CLEAR accept: out=0, step_cnt=0, go IDLE.
  - RUN_FREE accept: update dir only, stay.
  - LOAD, RUN_N, NOP accepts: consumed with no effect, and stepping still pauses that edge.
- Wrap: forward from 100..0 returns to 000..0. Reverse from 000..0 goes to 100..0.
- Direction change mid-free-run takes effect on the first step after the accept edge.
- Reset asserted mid-run: everything returns to reset values immediately; no done pulse.
- Simultaneous: err_illegal and a new accept in the same cycle are independent.

Test Plan:
- Reset then idle 5 cycles -> out=0000, busy=0, cmd_ready=1, step_cnt=0, done=0.
- RUN_N N=8, dir=1 from 0000 -> out sequence 0001,0011,0111,1111,1110,1100,1000,0000 on edges T+1..T+8; done high exactly one cycle; step_cnt=8; cmd_ready low throughout.
- LOAD 0011, then RUN_N N=3, dir=0 -> out 0001,0000,1000; done pulse; RUN_N N=0 -> done pulse next cycle, out unchanged at 1000.
- LOAD 0110 (illegal) -> out=0000, err_illegal one-cycle pulse; LOAD 1100 -> out=1100, no err.
- RUN_FREE dir=1 for 10 cycles, then STOP -> out advanced exactly 10 steps (0000 -> 0011 on 4-bit), holds after STOP edge, busy drops next cycle; RUN_FREE dir=0 mid-run reverses from next edge.
- Async reset pulse mid RUN_N (N=20, after 5 steps) -> out=0000, step_cnt=0, busy=0 immediately, no done pulse; new RUN_N after release behaves normally.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// rtl/johnson_seq_ctrl.sv - command-driven Johnson-counter phase sequencer
//
// Owns a WIDTH-bit Johnson phase register and moves it through its 2*WIDTH
// legal states. It can step a fixed count (RUN_N) or run until stopped
// (RUN_FREE), in either direction. Commands arrive over a valid/ready
// handshake. A LOAD of a non-Johnson code is replaced by all-zeros, and
// err_illegal pulses to report the repair.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    controller can accept a command (IDLE or RUN_FREE)
//   cmd_op       0 NOP, 1 CLEAR, 2 LOAD, 3 RUN_N, 4 RUN_FREE, 5 STOP, 6-7 NOP
//   cmd_dir      1 forward, 0 reverse; latched on RUN_N / RUN_FREE accept
//   cmd_arg      step count for RUN_N; [WIDTH-1:0] is the LOAD value
//   out          Johnson phase register
//   busy         controller not idle
//   done         one-cycle pulse after the last RUN_N step
//   err_illegal  one-cycle pulse after an illegal LOAD was repaired
//   step_cnt     steps since last CLEAR/reset, wraps modulo 2^CNT_W

module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_N    = 2'd1,
        S_RUN_FREE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] OP_CLEAR    = 3'd1;
    localparam logic [2:0] OP_LOAD     = 3'd2;
    localparam logic [2:0] OP_RUN_N    = 3'd3;
    localparam logic [2:0] OP_RUN_FREE = 3'd4;
    localparam logic [2:0] OP_STOP     = 3'd5;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             dir;

    logic             accept;
    logic             do_step;
    logic             do_clear;
    logic             do_load;
    logic             latch_dir;
    logic             load_rem;
    logic             dec_rem;

    logic [WIDTH-1:0] load_val;
    logic             load_legal;
    logic [WIDTH-1:0] step_val;
    logic             arg_zero;
    logic             rem_last;

    // A code is a Johnson state when adjacent bits differ in at most one place.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) begin
                n++;
            end
        end
        return (n <= 1);
    endfunction

    function automatic logic [WIDTH-1:0] fwd_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ~v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rev_step(input logic [WIDTH-1:0] v);
        return {~v[0], v[WIDTH-1:1]};
    endfunction

    // Handshake depends on state only, never on cmd_valid.
    assign cmd_ready  = (state == S_IDLE) || (state == S_RUN_FREE);
    assign accept     = cmd_valid && cmd_ready;

    assign load_val   = cmd_arg[WIDTH-1:0];
    assign load_legal = is_legal(load_val);
    assign step_val   = dir ? fwd_step(out) : rev_step(out);
    assign arg_zero   = (cmd_arg == '0);
    assign rem_last   = (remaining == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_RUN_N) begin
                        state_nxt = arg_zero ? S_DONE : S_RUN_N;
                    end else if (cmd_op == OP_RUN_FREE) begin
                        state_nxt = S_RUN_FREE;
                    end
                end
            end
            S_RUN_N: begin
                // remaining is never 0 here: RUN_N is entered only with N>0.
                if (rem_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_RUN_FREE: begin
                if (accept && (cmd_op == OP_STOP || cmd_op == OP_CLEAR)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output and datapath-strobe logic
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        do_step   = 1'b0;
        do_clear  = 1'b0;
        do_load   = 1'b0;
        latch_dir = 1'b0;
        load_rem  = 1'b0;
        dec_rem   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_CLEAR: do_clear = 1'b1;
                        OP_LOAD:  do_load  = 1'b1;
                        OP_RUN_N: begin
                            latch_dir = !arg_zero;
                            load_rem  = !arg_zero;
                        end
                        OP_RUN_FREE: latch_dir = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN_N: begin
                do_step = 1'b1;
                dec_rem = 1'b1;
            end
            S_RUN_FREE: begin
                // Any accepted command, even a NOP, pauses stepping that edge.
                if (accept) begin
                    if (cmd_op == OP_CLEAR) begin
                        do_clear = 1'b1;
                    end else if (cmd_op == OP_RUN_FREE) begin
                        latch_dir = 1'b1;
                    end
                end else begin
                    do_step = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Phase register, step counter, run length, direction, error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out         <= '0;
            step_cnt    <= '0;
            remaining   <= '0;
            dir         <= 1'b1;
            err_illegal <= 1'b0;
        end else begin
            if (do_clear) begin
                out      <= '0;
                step_cnt <= '0;
            end else if (do_load) begin
                out <= load_legal ? load_val : '0;
            end else if (do_step) begin
                out      <= step_val;
                step_cnt <= step_cnt + CNT_W'(1);
            end

            err_illegal <= do_load && !load_legal;

            if (latch_dir) begin
                dir <= cmd_dir;
            end

            if (load_rem) begin
                remaining <= cmd_arg;
            end else if (dec_rem) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb/tb_johnson_seq_ctrl.sv - self-checking bench for johnson_seq_ctrl
module tb_johnson_seq_ctrl;

    localparam int W = 4;
    localparam int C = 8;
    localparam int NSTATES = 2 * W;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_FREE = 2;
    localparam int M_DONE = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic         cmd_dir = 1'b0;
    logic [C-1:0] cmd_arg = '0;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         err_illegal;
    logic [C-1:0] step_cnt;

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_dir(cmd_dir),
        .cmd_arg(cmd_arg),
        .out(out),
        .busy(busy),
        .done(done),
        .err_illegal(err_illegal),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase kept as an index into the ring of 2*W states.
    int m_idx, m_cnt, m_rem, m_mode, m_dir, m_err;

    function automatic logic [W-1:0] johnson(input int k);
        int v;
        if (k < W) v = (1 << k) - 1;
        else       v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
        return W'(v);
    endfunction

    function automatic int find_idx(input logic [W-1:0] val);
        for (int k = 0; k < NSTATES; k++) begin
            if (johnson(k) == val) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_rem = 0; m_mode = M_IDLE; m_dir = 1; m_err = 0;
    endtask

    task automatic model_advance();
        m_idx = m_dir ? (m_idx + 1) % NSTATES : (m_idx + NSTATES - 1) % NSTATES;
        m_cnt = (m_cnt + 1) % (1 << C);
    endtask

    function automatic logic model_ready();
        return (m_mode == M_IDLE) || (m_mode == M_FREE);
    endfunction

    task automatic model_edge(input logic v, input logic [2:0] op, input logic d, input logic [C-1:0] arg);
        logic acc;
        int   k;
        acc   = v && model_ready();
        m_err = 0;
        case (m_mode)
            M_IDLE: if (acc) begin
                case (op)
                    3'd1: begin m_idx = 0; m_cnt = 0; end
                    3'd2: begin
                        k = find_idx(arg[W-1:0]);
                        if (k < 0) begin m_idx = 0; m_err = 1; end
                        else m_idx = k;
                    end
                    3'd3: begin
                        if (arg != 0) begin m_dir = d; m_rem = arg; m_mode = M_RUN; end
                        else m_mode = M_DONE;
                    end
                    3'd4: begin m_dir = d; m_mode = M_FREE; end
                    default: ;
                endcase
            end
            M_RUN: begin
                model_advance();
                m_rem--;
                if (m_rem == 0) m_mode = M_DONE;
            end
            M_DONE: m_mode = M_IDLE;
            M_FREE: begin
                if (acc) begin
                    if (op == 3'd5) m_mode = M_IDLE;
                    else if (op == 3'd1) begin m_idx = 0; m_cnt = 0; m_mode = M_IDLE; end
                    else if (op == 3'd4) m_dir = d;
                end else begin
                    model_advance();
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out"}, 32'(out), 32'(johnson(m_idx)));
        chk({tag, ".step_cnt"}, 32'(step_cnt), 32'(m_cnt));
        chk({tag, ".busy"}, 32'(busy), 32'(m_mode != M_IDLE));
        chk({tag, ".done"}, 32'(done), 32'(m_mode == M_DONE));
        chk({tag, ".err"}, 32'(err_illegal), 32'(m_err));
    endtask

    // One clock cycle: drive at posedge+1, check ready before the edge,
    // check registered outputs at posedge+1.
    task automatic cyc(input logic v, input logic [2:0] op, input logic d, input logic [C-1:0] arg);
        cmd_valid = v; cmd_op = op; cmd_dir = d; cmd_arg = arg;
        #1;
        chk("cmd_ready", 32'(cmd_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge(v, op, d, arg);
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, '0);
    endtask

    initial begin
        int dcount;
        logic v;
        logic [2:0] op;
        logic [C-1:0] arg;

        model_reset();
        #12;
        check_outputs("in_reset");
        #1 reset = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 3'd0, 1'b0, '0);
        #1;
        check_outputs("post_reset");
        idle(5);
        chk("reset_ready", 32'(cmd_ready), 32'd1);

        // RUN_N 8 forward from 0000
        cyc(1'b1, 3'd3, 1'b1, 8'd8);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 3'd0, 1'b0, '0);
            if (done) dcount++;
        end
        chk("run8_done_pulses", 32'(dcount), 32'd1);
        chk("run8_out", 32'(out), 32'h0);
        chk("run8_cnt", 32'(step_cnt), 32'd8);

        // LOAD 0011, reverse 3 steps, then N=0
        cyc(1'b1, 3'd2, 1'b0, 8'h03);
        cyc(1'b1, 3'd3, 1'b0, 8'd3);
        idle(5);
        chk("rev3_out", 32'(out), 32'h8);
        cyc(1'b1, 3'd3, 1'b1, 8'd0);
        chk("n0_done", 32'(done), 32'd1);
        idle(2);
        chk("n0_out", 32'(out), 32'h8);

        // Illegal then legal load
        cyc(1'b1, 3'd2, 1'b0, 8'h06);
        chk("illegal_err", 32'(err_illegal), 32'd1);
        idle(1);
        cyc(1'b1, 3'd2, 1'b0, 8'h0C);
        chk("legal_out", 32'(out), 32'hC);
        idle(1);

        // Free run forward 10 steps then STOP
        cyc(1'b1, 3'd1, 1'b0, '0);
        cyc(1'b1, 3'd4, 1'b1, '0);
        idle(10);
        cyc(1'b1, 3'd5, 1'b0, '0);
        chk("free10_out", 32'(out), 32'h3);
        idle(2);

        // Mid-run reversal, NOP pause, then STOP
        cyc(1'b1, 3'd4, 1'b1, '0);
        idle(3);
        cyc(1'b1, 3'd4, 1'b0, '0);
        idle(4);
        cyc(1'b1, 3'd0, 1'b0, '0);
        idle(2);
        cyc(1'b1, 3'd5, 1'b0, '0);
        idle(2);

        // step_cnt wrap
        cyc(1'b1, 3'd3, 1'b1, 8'd255);
        idle(256);
        cyc(1'b1, 3'd3, 1'b0, 8'd3);
        idle(5);

        // Async reset mid RUN_N
        cyc(1'b1, 3'd3, 1'b1, 8'd20);
        idle(5);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        #1 reset = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 3'd0, 1'b0, '0);
        #1;
        check_outputs("after_release");
        cyc(1'b1, 3'd3, 1'b1, 8'd6);
        idle(8);

        // Randomized commands against the model
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            if (op == 3'd3) arg = C'($urandom_range(0, 12));
            else            arg = C'($urandom_range(0, 255));
            cyc(v, op, 1'($urandom_range(0, 1)), arg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
